// File: rtl/uart_rx_byte.sv
// uart_rx_byte
// Receives one 8N1 UART frame (start, 8 data bits LSB first, stop) from an
// asynchronous, idle-high rx line. A good frame updates data and produces a
// one-cycle dataValid strobe. A frame whose stop bit is sampled low produces a
// one-cycle frameError strobe instead and leaves data unchanged.
//
// Bit timing is derived from N = ClockFrequency/BaudRate clocks per bit.
// The start bit is confirmed at half a bit (H = N/2). Every later bit is
// sampled one full bit period after the previous sample point.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | line idle, waiting for a low level on the synchronised rx
// START | counting to mid start bit; high there means a glitch, back to IDLE
// DATA  | sampling 8 data bits at mid-bit, LSB first
// STOP  | sampling the stop bit; high -> byte out, low -> frame error
// BREAK | line held low after a bad stop bit; wait for it to return high

module uart_rx_byte #(
    parameter int ClockFrequency = 1000000,
    parameter int BaudRate       = 9600
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       dataValid,
    output logic       frameError,
    output logic       busy
);

    localparam int N  = ClockFrequency / BaudRate;
    localparam int H  = N / 2;
    localparam int CW = $clog2(N) + 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic          r_rx_meta;
    logic          r_rx_sync;
    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_ferr;

    logic          w_rxs;
    logic          w_cnt_last;
    logic          w_cnt_half;
    logic          w_stop_sample;
    logic          w_data_sample;
    logic          w_cnt_clr;
    logic          w_cnt_run;
    logic [2:0]    w_state_nxt;

    assign w_rxs         = r_rx_sync;
    assign w_cnt_last    = (r_cnt == CNT_LAST);
    assign w_cnt_half    = (r_cnt == CNT_HALF);
    assign w_data_sample = (r_state == S_DATA) && w_cnt_last;
    assign w_stop_sample = (r_state == S_STOP) && w_cnt_last;

    // Two-flop synchroniser for the asynchronous rx pin; idles high.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Next-state decode; every decision looks only at the synchronised line.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_rxs) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_cnt_half) begin
                    w_state_nxt = w_rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_cnt_last && (r_bit_idx == 3'd7)) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_cnt_last) begin
                    w_state_nxt = w_rxs ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                if (w_rxs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // The bit counter restarts on every state change and after each data
    // sample, and only runs in the states that time a bit.
    assign w_cnt_clr = (w_state_nxt != r_state) || w_data_sample;
    assign w_cnt_run = (r_state == S_START) || (r_state == S_DATA) ||
                       (r_state == S_STOP);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bit-period counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_cnt_clr || !w_cnt_run) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    // Data bit index: cleared on entry to DATA, advanced after each sample.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_bit_idx <= 3'd0;
        end else if ((r_state == S_START) && (w_state_nxt == S_DATA)) begin
            r_bit_idx <= 3'd0;
        end else if (w_data_sample) begin
            r_bit_idx <= r_bit_idx + 3'd1;
        end
    end

    // Shift register collecting data bits LSB first at mid-bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_shift <= 8'h00;
        end else if (w_data_sample) begin
            r_shift[r_bit_idx] <= w_rxs;
        end
    end

    // Output byte only changes on a good stop bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_data <= 8'h00;
        end else if (w_stop_sample && w_rxs) begin
            r_data <= r_shift;
        end
    end

    // One-cycle strobes; they come from the same stop sample so they are
    // mutually exclusive by construction.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_valid <= w_stop_sample && w_rxs;
            r_ferr  <= w_stop_sample && !w_rxs;
        end
    end

    assign data       = r_data;
    assign dataValid  = r_valid;
    assign frameError = r_ferr;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte: a table of frames on a fast instance
// (N=16, H=8) plus hand sequences for back-to-back frames, a start glitch,
// mid-frame reset and one frame on a default-parameter instance (N=104).

module tb_uart_rx_byte;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rx    = 1'b1;
    logic       rx2   = 1'b1;
    logic [7:0] data, data2;
    logic       dv, fe, busy;
    logic       dv2, fe2, busy2;

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    int v_cnt = 0, f_cnt = 0, last_v = 0, last_f = 0, both = 0;
    int v2_cnt = 0, f2_cnt = 0, last_v2 = 0;
    int busy_drop = 0;
    bit win_on = 1'b0;
    int win_lo = 0, win_hi = 0;
    int start_cyc = 0;

    uart_rx_byte #(.ClockFrequency(16), .BaudRate(1)) dut (
        .clock(clock), .reset(reset), .rx(rx), .data(data),
        .dataValid(dv), .frameError(fe), .busy(busy)
    );

    uart_rx_byte dut_def (
        .clock(clock), .reset(reset), .rx(rx2), .data(data2),
        .dataValid(dv2), .frameError(fe2), .busy(busy2)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (dv) begin v_cnt++; last_v = cyc; end
        if (fe) begin f_cnt++; last_f = cyc; end
        if (dv && fe) both++;
        if (dv2) begin v2_cnt++; last_v2 = cyc; end
        if (fe2) f2_cnt++;
        if (win_on && cyc >= win_lo && cyc <= win_hi && !busy) busy_drop++;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic hold(input bit sel, input logic v, input int n);
        if (sel) rx2 = v; else rx = v;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] b, input logic stop, input int n);
        start_cyc = cyc;
        if (!sel) begin
            win_lo = cyc + 3;
            win_hi = cyc + 2 + n / 2 + 9 * n;
            win_on = 1'b1;
        end
        hold(sel, 1'b0, n);
        for (int i = 0; i < 8; i++) hold(sel, b[i], n);
        hold(sel, stop, n);
        win_on = 1'b0;
    endtask

    typedef struct {
        logic [7:0] din;
        logic       stop;
        int         tail;
        int         exp_v;
        int         exp_f;
        logic [7:0] exp_d;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int v0, f0, bd0, v20, f20;

        vecs[0] = '{8'h55, 1'b1,  0, 1, 0, 8'h55};
        vecs[1] = '{8'h00, 1'b1,  0, 1, 0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1,  0, 1, 0, 8'hFF};
        vecs[3] = '{8'h81, 1'b0, 40, 0, 1, 8'hFF};
        vecs[4] = '{8'h3C, 1'b1,  0, 1, 0, 8'h3C};
        vecs[5] = '{8'h96, 1'b0,  0, 0, 1, 8'h3C};
        vecs[6] = '{8'h01, 1'b1,  0, 1, 0, 8'h01};

        repeat (3) @(posedge clock);
        #1;
        chk("rst_data", int'(data), 0);
        chk("rst_valid", int'(dv), 0);
        chk("rst_ferr", int'(fe), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_data_def", int'(data2), 0);
        reset = 1'b1;
        hold(0, 1'b1, 5);

        for (int i = 0; i < 7; i++) begin
            v0 = v_cnt; f0 = f_cnt; bd0 = busy_drop;
            send_frame(0, vecs[i].din, vecs[i].stop, 16);
            if (vecs[i].tail > 0) begin
                hold(0, 1'b0, vecs[i].tail);
                chk($sformatf("v%0d_break_busy", i), int'(busy), 1);
                chk($sformatf("v%0d_break_nopulse", i), v_cnt - v0, 0);
            end
            hold(0, 1'b1, 20);
            chk($sformatf("v%0d_valid_cnt", i), v_cnt - v0, vecs[i].exp_v);
            chk($sformatf("v%0d_ferr_cnt", i), f_cnt - f0, vecs[i].exp_f);
            chk($sformatf("v%0d_data", i), int'(data), int'(vecs[i].exp_d));
            chk($sformatf("v%0d_busy_held", i), busy_drop - bd0, 0);
            chk($sformatf("v%0d_idle_busy", i), int'(busy), 0);
            if (vecs[i].exp_v != 0)
                chk_rng($sformatf("v%0d_valid_lat", i), last_v - start_cyc, 154, 155);
            if (vecs[i].exp_f != 0)
                chk_rng($sformatf("v%0d_ferr_lat", i), last_f - start_cyc, 154, 155);
        end

        // back-to-back frames, no idle between stop and next start
        v0 = v_cnt; bd0 = busy_drop;
        send_frame(0, 8'hA3, 1'b1, 16);
        chk("b2b_first_data", int'(data), 8'hA3);
        chk("b2b_first_cnt", v_cnt - v0, 1);
        send_frame(0, 8'h0F, 1'b1, 16);
        hold(0, 1'b1, 20);
        chk("b2b_second_data", int'(data), 8'h0F);
        chk("b2b_second_cnt", v_cnt - v0, 2);
        chk_rng("b2b_second_lat", last_v - start_cyc, 154, 155);
        chk("b2b_busy_held", busy_drop - bd0, 0);

        // short low glitch: rejected at the mid start-bit sample
        v0 = v_cnt; f0 = f_cnt;
        hold(0, 1'b0, 4);
        chk("glitch_busy_start", int'(busy), 1);
        hold(0, 1'b1, 20);
        chk("glitch_busy_end", int'(busy), 0);
        chk("glitch_valid", v_cnt - v0, 0);
        chk("glitch_ferr", f_cnt - f0, 0);
        chk("glitch_data", int'(data), 8'h0F);

        // reset asserted in the middle of an 0xFF frame
        v0 = v_cnt; f0 = f_cnt;
        hold(0, 1'b0, 16);
        hold(0, 1'b1, 48);
        reset = 1'b0;
        #1;
        chk("midrst_data", int'(data), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_valid", int'(dv), 0);
        hold(0, 1'b1, 3);
        reset = 1'b1;
        hold(0, 1'b1, 16 * 6 + 40);
        chk("postrst_valid", v_cnt - v0, 0);
        chk("postrst_ferr", f_cnt - f0, 0);
        chk("postrst_data", int'(data), 0);
        chk("postrst_busy", int'(busy), 0);

        // default parameters: N=104, H=52
        v20 = v2_cnt; f20 = f2_cnt;
        hold(1, 1'b1, 5);
        send_frame(1, 8'hC7, 1'b1, 104);
        hold(1, 1'b1, 40);
        chk("def_data", int'(data2), 8'hC7);
        chk("def_valid_cnt", v2_cnt - v20, 1);
        chk("def_ferr_cnt", f2_cnt - f20, 0);
        chk_rng("def_valid_lat", last_v2 - start_cyc, 990, 991);
        chk("def_busy_idle", int'(busy2), 0);

        chk("valid_ferr_overlap", both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
